// File: rtl/ram_reader_if.sv
// Read-side bus of the sample RAM reader: RAM read port plus the valid/ready word output.
// A word transfers on a rising edge where rd_valid & rd_ready; rd_data is stable while rd_valid is high.
interface ram_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
);
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;

  modport master (
    output ram_rd_en, ram_rd_addr, rd_data, rd_valid,
    input  ram_rd_data, rd_ready
  );

  modport slave (
    input  ram_rd_en, ram_rd_addr, rd_data, rd_valid,
    output ram_rd_data, rd_ready
  );
endinterface

// File: rtl/ram_reader.sv
// Read-side addresser for the 2048 x 8 sample RAM: walks the writer's descending address ring and streams words out.
// Optional sticky overflow flag (ports ovf/ovf_clr) is enabled by defining RAM_READER_OVF_EN.
module ram_reader #(
  parameter int              DATA_W     = 8,
  parameter int              ADDR_W     = 11,
  parameter logic [ADDR_W-1:0] START_ADDR = {ADDR_W{1'b1}}
) (
  input  logic            clk_2,
  input  logic            reset_n,
  input  logic            wr_ena,
  ram_reader_if.master    bus,
  output logic [ADDR_W:0] count,
  output logic [1:0]      fsm_state
`ifdef RAM_READER_OVF_EN
  ,
  output logic            ovf,
  input  logic            ovf_clr
`endif
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [DATA_W-1:0]   data_q;
  logic                full_wr;
  logic                avail;
  logic                issue;

  // A write while full overwrites the oldest unread word, so no fetch may target it this cycle.
  assign full_wr = (count == DEPTH) && wr_ena;
  assign avail   = (count != '0) && !full_wr;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (avail) begin
          issue     = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = HOLD;
      HOLD: begin
        if (bus.rd_ready) begin
          if (avail) begin
            issue     = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The pointer also steps on an overflow write so it skips the word the writer just destroyed.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= START_ADDR;
    end else if (issue || full_wr) begin
      rd_ptr <= (rd_ptr == '0) ? START_ADDR : rd_ptr - 1'b1;
    end
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      case ({wr_ena, issue})
        2'b10:   if (count != DEPTH) count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
    end else if (state == FETCH) begin
      data_q <= bus.ram_rd_data;
    end
  end

`ifdef RAM_READER_OVF_EN
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= 1'b0;
    end else if (full_wr) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`endif

  assign bus.ram_rd_en   = issue;
  assign bus.ram_rd_addr = rd_ptr;
  assign bus.rd_data     = data_q;
  assign bus.rd_valid    = (state == HOLD);
  assign fsm_state       = state;

endmodule

// File: tb/tb_ram_reader.sv
// Directed bench for ram_reader: models the writer and the synchronous RAM, checks addresses and word order.
module tb_ram_reader;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2048;

  logic              clk_2   = 1'b0;
  logic              reset_n = 1'b0;
  logic              wr_ena  = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [ADDR_W:0]   count;
  logic [1:0]        fsm_state;
`ifdef RAM_READER_OVF_EN
  logic              ovf;
  logic              ovf_clr = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int fetches = 0;
  int skips = 0;
  logic [DATA_W-1:0] exp_q[$];

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [ADDR_W-1:0] wr_addr;

  ram_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_2     (clk_2),
    .reset_n   (reset_n),
    .wr_ena    (wr_ena),
    .bus       (bus.master),
    .count     (count),
    .fsm_state (fsm_state)
`ifdef RAM_READER_OVF_EN
    ,
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
`endif
  );

  // clock/reset
  always #5 clk_2 = ~clk_2;

  // writer and synchronous RAM model
  always @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr <= 11'h7FF;
    end else if (wr_ena) begin
      mem[wr_addr] <= wr_data;
      wr_addr      <= wr_addr - 1'b1;
    end
  end

  always @(posedge clk_2) begin
    if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: fetch addresses follow the descending ring, words come out in write order
  always @(negedge clk_2) begin
    if (!reset_n) begin
      fetches <= 0;
    end else begin
      if (bus.ram_rd_en) begin
        chk("rd_addr_seq", 32'(bus.ram_rd_addr), 32'(11'(32'h7FF - fetches - skips)));
        fetches <= fetches + 1;
      end
      if (bus.rd_valid && bus.rd_ready) begin
        if (exp_q.size() == 0) chk("spurious_word", 32'(bus.rd_valid), 32'd0);
        else chk("rd_data_seq", 32'(bus.rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic write_word(input logic [DATA_W-1:0] d);
    wr_data = d;
    wr_ena  = 1'b1;
    exp_q.push_back(d);
    tick();
    wr_ena = 1'b0;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    wr_ena       = 1'b0;
    bus.rd_ready = 1'b0;
    skips        = 0;
    exp_q.delete();
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_addr", 32'(bus.ram_rd_addr), 32'h7FF);
    chk("rst_rd_en", 32'(bus.ram_rd_en), 32'd0);
    chk("rst_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_data", 32'(bus.rd_data), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && fsm_state == 2'd0 && count == '0) break;
      tick();
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.rd_ready = 1'b0;
    tick();
    do_reset();

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_rd_en", 32'(bus.ram_rd_en), 32'd0);
      chk("idle_count", 32'(count), 32'd0);
      chk("idle_valid", 32'(bus.rd_valid), 32'd0);
      chk("idle_addr", 32'(bus.ram_rd_addr), 32'h7FF);
    end

    // single word: fetch the cycle after count becomes 1, valid two edges later
    bus.rd_ready = 1'b1;
    write_word(8'hA5);
    #1;
    chk("single_count", 32'(count), 32'd1);
    chk("single_rd_en", 32'(bus.ram_rd_en), 32'd1);
    chk("single_addr", 32'(bus.ram_rd_addr), 32'h7FF);
    tick();
    chk("single_fetch_state", 32'(fsm_state), 32'd1);
    chk("single_fetch_valid", 32'(bus.rd_valid), 32'd0);
    chk("single_fetch_addr", 32'(bus.ram_rd_addr), 32'h7FE);
    tick();
    chk("single_valid", 32'(bus.rd_valid), 32'd1);
    chk("single_data", 32'(bus.rd_data), 32'hA5);
    tick();
    chk("single_idle_state", 32'(fsm_state), 32'd0);
    chk("single_idle_valid", 32'(bus.rd_valid), 32'd0);
    chk("single_next_addr", 32'(bus.ram_rd_addr), 32'h7FE);

    // backpressure: one fetch, word held, two unread words waiting
    bus.rd_ready = 1'b0;
    write_word(8'h11);
    write_word(8'h22);
    write_word(8'h33);
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", 32'(bus.rd_valid), 32'd1);
      chk("bp_data", 32'(bus.rd_data), 32'h11);
      chk("bp_count", 32'(count), 32'd2);
      chk("bp_rd_en", 32'(bus.ram_rd_en), 32'd0);
      tick();
    end
    bus.rd_ready = 1'b1;
    #1;
    chk("bp_resume_rd_en", 32'(bus.ram_rd_en), 32'd1);
    chk("bp_resume_addr", 32'(bus.ram_rd_addr), 32'h7FD);
    tick();
    tick();
    chk("bp_word2_valid", 32'(bus.rd_valid), 32'd1);
    chk("bp_word2_data", 32'(bus.rd_data), 32'h22);
    tick();
    tick();
    chk("bp_word3_valid", 32'(bus.rd_valid), 32'd1);
    chk("bp_word3_data", 32'(bus.rd_data), 32'h33);
    wait_idle(50);
    chk("bp_end_addr", 32'(bus.ram_rd_addr), 32'h7FB);

    // reset while a word is held discards it
    bus.rd_ready = 1'b0;
    write_word(8'h44);
    write_word(8'h55);
    tick();
    chk("midrst_held", 32'(bus.rd_valid), 32'd1);
    do_reset();

    // write on the same edge as an issue with count = 5
    for (int i = 0; i < 6; i++) write_word(8'h60 + 8'(i));
    chk("sim_pre_count", 32'(count), 32'd5);
    chk("sim_pre_state", 32'(fsm_state), 32'd2);
    wr_data = 8'h66;
    wr_ena  = 1'b1;
    exp_q.push_back(8'h66);
    bus.rd_ready = 1'b1;
    #1;
    chk("sim_rd_en", 32'(bus.ram_rd_en), 32'd1);
    tick();
    wr_ena = 1'b0;
    chk("sim_count", 32'(count), 32'd5);
    chk("sim_state", 32'(fsm_state), 32'd1);
    wait_idle(100);

    // overflow: fill to DEPTH unread words, then one more write with the consumer ready
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) write_word(8'(i) ^ 8'h5A);
    chk("ovf_full_count", 32'(count), 32'd2048);
    chk("ovf_full_addr", 32'(bus.ram_rd_addr), 32'h7FE);
    chk("ovf_full_state", 32'(fsm_state), 32'd2);
    wr_data = 8'(DEPTH + 1) ^ 8'h5A;
    wr_ena  = 1'b1;
    exp_q.delete(1);
    exp_q.push_back(wr_data);
    bus.rd_ready = 1'b1;
    #1;
    chk("ovf_issue_blocked", 32'(bus.ram_rd_en), 32'd0);
    tick();
    wr_ena       = 1'b0;
    bus.rd_ready = 1'b0;
    skips        = 1;
    chk("ovf_count", 32'(count), 32'd2048);
    chk("ovf_skip_addr", 32'(bus.ram_rd_addr), 32'h7FD);
    chk("ovf_state", 32'(fsm_state), 32'd0);
`ifdef RAM_READER_OVF_EN
    chk("ovf_flag_set", 32'(ovf), 32'd1);
    tick();
    chk("ovf_flag_sticky", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_flag_clr", 32'(ovf), 32'd0);
`endif
    bus.rd_ready = 1'b1;
    wait_idle(5000);

    // wrap: interleaved writes and reads across the whole ring and past it
    do_reset();
    bus.rd_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      write_word(8'(i) ^ 8'hC3);
      tick();
    end
    wait_idle(200);
    chk("wrap_fetches", 32'(fetches), 32'd2050);
    chk("wrap_end_addr", 32'(bus.ram_rd_addr), 32'h7FD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
